// File: rtl/ireg_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package ireg_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned AW_DEF    = $clog2(NREG_DEF);
  localparam int unsigned ZERO_ADDR = 0;

  typedef logic [AW_DEF-1:0] reg_addr_t;

  // Source of read data in the cycle after the address was presented.
  typedef enum logic [1:0] {
    BYP_ARR,
    BYP_X,
    BYP_M,
    BYP_L
  } byp_sel_t;

endpackage

// File: rtl/ireg_mp_if.sv
// Decode/execute-side bundle for ireg_mp: read ports, X and late writes, load issue.
interface ireg_mp_if
  import ireg_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                wx_v;
  logic [AW-1:0]       wx_addr;
  logic [XLEN-1:0]     wx_data;
  logic                wl_v;
  logic [AW-1:0]       wl_addr;
  logic [XLEN-1:0]     wl_data;
  logic                ld_issue_v;
  logic [AW-1:0]       ld_issue_addr;
  logic                pending_any;

  modport master (
    output rs_addr, wx_v, wx_addr, wx_data, wl_v, wl_addr, wl_data,
    output ld_issue_v, ld_issue_addr,
    input  rs_data, rs_busy, pending_any
  );

  modport slave (
    input  rs_addr, wx_v, wx_addr, wx_data, wl_v, wl_addr, wl_data,
    input  ld_issue_v, ld_issue_addr,
    output rs_data, rs_busy, pending_any
  );

endinterface

// File: rtl/ireg_scoreboard.sv
// Per-register pending bits for outstanding late writes, plus registered
// per-port busy flags and the pending_any summary.
module ireg_scoreboard
  import ireg_pkg::*;
#(
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_set_v,
  input  logic [$clog2(NREG)-1:0]       i_set_addr,
  input  logic                          i_clr_v,
  input  logic [$clog2(NREG)-1:0]       i_clr_addr,
  input  logic [NRD*$clog2(NREG)-1:0]   i_rd_addr,
  output logic [NRD-1:0]                o_rs_busy,
  output logic                          o_pending_any
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_d;
  logic            w_set_v;
  logic [NRD-1:0]  w_busy;
  logic [NRD-1:0]  r_busy;
  logic            r_pending_any;

  assign w_set_v = i_set_v && !((ZERO_REG != 0) && (i_set_addr == AW'(ZERO_ADDR)));

  // Set is applied after clear so a new load issue survives the old return.
  always_comb begin
    w_pend_d = r_pend;
    if (i_clr_v) w_pend_d[i_clr_addr] = 1'b0;
    if (w_set_v) w_pend_d[i_set_addr] = 1'b1;
  end

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_busy[i] = (r_pend[i_rd_addr[i*AW +: AW]] &
                   ~(i_clr_v && (i_clr_addr == i_rd_addr[i*AW +: AW]))) |
                  (w_set_v && (i_set_addr == i_rd_addr[i*AW +: AW]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend        <= '0;
      r_busy        <= '0;
      r_pending_any <= 1'b0;
    end else begin
      r_pend        <= w_pend_d;
      r_busy        <= w_busy;
      r_pending_any <= |w_pend_d;
    end
  end

  assign o_rs_busy     = r_busy;
  assign o_pending_any = r_pending_any;

endmodule

// File: rtl/ireg_mp.sv
// Multi-port integer register file with X/M/late-write bypass, a late write
// port for load returns and a pending scoreboard for decode stalls.
module ireg_mp
  import ireg_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic      clk,
  input logic      rst_n,
  ireg_mp_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] r_mem [NREG];
  logic            r_m_v;
  logic [AW-1:0]   r_m_addr;
  logic [XLEN-1:0] r_m_data;
  logic            r_w_v;
  logic [XLEN-1:0] r_w_data;
  logic [XLEN-1:0] r_l_data;
  logic            w_wx_we;
  logic            w_wl_we;
  logic [XLEN-1:0] w_port_data [NRD];

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == AW'(ZERO_ADDR));
  endfunction

  assign w_wx_we = bus.wx_v & ~is_zero(bus.wx_addr);
  assign w_wl_we = bus.wl_v & ~is_zero(bus.wl_addr);

  // M holds last cycle's X result; W holds last cycle's M for one more bypass cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_v    <= 1'b0;
      r_m_addr <= '0;
      r_m_data <= '0;
      r_w_v    <= 1'b0;
      r_w_data <= '0;
      r_l_data <= '0;
    end else begin
      r_m_v <= w_wx_we;
      r_w_v <= r_m_v;
      if (w_wx_we) begin
        r_m_addr <= bus.wx_addr;
        r_m_data <= bus.wx_data;
      end
      if (r_m_v) r_w_data <= r_m_data;
      if (w_wl_we) r_l_data <= bus.wl_data;
    end
  end

  // M is written last so it wins a same-address collision with the late port.
  always_ff @(posedge clk) begin
    if (w_wl_we) r_mem[bus.wl_addr] <= bus.wl_data;
    if (r_m_v)   r_mem[r_m_addr]    <= r_m_data;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   w_addr;
    byp_sel_t        w_sel;
    byp_sel_t        r_sel;
    logic [XLEN-1:0] r_arr;
    logic [XLEN-1:0] w_data;

    assign w_addr = bus.rs_addr[gi*AW +: AW];

    always_comb begin
      w_sel = BYP_ARR;
      if (is_zero(w_addr)) begin
        w_sel = BYP_ARR;
      end else if (w_wx_we && (bus.wx_addr == w_addr)) begin
        w_sel = BYP_X;
      end else if (r_m_v && (r_m_addr == w_addr)) begin
        w_sel = BYP_M;
      end else if (w_wl_we && (bus.wl_addr == w_addr)) begin
        w_sel = BYP_L;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sel <= BYP_ARR;
        r_arr <= '0;
      end else begin
        r_sel <= w_sel;
        r_arr <= is_zero(w_addr) ? '0 : r_mem[w_addr];
      end
    end

    // X and M selections have advanced one stage by the time they are muxed.
    always_comb begin
      w_data = r_arr;
      unique case (r_sel)
        BYP_ARR: w_data = r_arr;
        BYP_X:   w_data = r_m_data;
        BYP_M:   w_data = r_w_data;
        BYP_L:   w_data = r_l_data;
      endcase
    end

    assign w_port_data[gi] = w_data;
  end

  always_comb begin
    bus.rs_data = '0;
    for (int i = 0; i < NRD; i++) begin
      bus.rs_data[i*XLEN +: XLEN] = w_port_data[i];
    end
  end

  ireg_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_set_v       (bus.ld_issue_v),
    .i_set_addr    (bus.ld_issue_addr),
    .i_clr_v       (bus.wl_v),
    .i_clr_addr    (bus.wl_addr),
    .i_rd_addr     (bus.rs_addr),
    .o_rs_busy     (bus.rs_busy),
    .o_pending_any (bus.pending_any)
  );

  // The scoreboard must stall a late write that would land on an in-flight M write.
  a_no_wr_collision: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_m_v && w_wl_we && (r_m_addr == bus.wl_addr)));

endmodule

// File: tb/tb_ireg_mp.sv
// Directed self-checking bench for ireg_mp: a default 2-port/32-bit instance
// and a 3-port/64-bit/16-register instance.
module tb_ireg_mp;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ireg_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) if_a ();
  ireg_mp_if #(.XLEN(64), .NREG(16), .NRD(3)) if_b ();

  ireg_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  ireg_mp #(.XLEN(64), .NREG(16), .NRD(3), .ZERO_REG(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    if_a.rs_addr       = '0;
    if_a.wx_v          = 1'b0;
    if_a.wx_addr       = '0;
    if_a.wx_data       = '0;
    if_a.wl_v          = 1'b0;
    if_a.wl_addr       = '0;
    if_a.wl_data       = '0;
    if_a.ld_issue_v    = 1'b0;
    if_a.ld_issue_addr = '0;
  endtask

  task automatic idle_b();
    if_b.rs_addr       = '0;
    if_b.wx_v          = 1'b0;
    if_b.wx_addr       = '0;
    if_b.wx_data       = '0;
    if_b.wl_v          = 1'b0;
    if_b.wl_addr       = '0;
    if_b.wl_data       = '0;
    if_b.ld_issue_v    = 1'b0;
    if_b.ld_issue_addr = '0;
  endtask

  task automatic test_reset();
    idle_a();
    idle_b();
    rst_n = 1'b0;
    if_a.rs_addr = {5'd0, 5'd5};
    step();
    step();
    checks++;
    if (if_a.rs_data !== 64'h0) begin
      errors++; $display("FAIL reset_data_a: got %h want 0", if_a.rs_data);
    end
    checks++;
    if (if_a.rs_busy !== 2'b00) begin
      errors++; $display("FAIL reset_busy_a: got %b want 00", if_a.rs_busy);
    end
    checks++;
    if (if_a.pending_any !== 1'b0) begin
      errors++; $display("FAIL reset_pend_a: got %b want 0", if_a.pending_any);
    end
    checks++;
    if (if_b.rs_data !== 192'h0) begin
      errors++; $display("FAIL reset_data_b: got %h want 0", if_b.rs_data);
    end
    checks++;
    if (if_b.rs_busy !== 3'b000) begin
      errors++; $display("FAIL reset_busy_b: got %b want 000", if_b.rs_busy);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (if_a.rs_data[63:32] !== 32'h0 || if_a.rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_r0: data %h busy %b want 0/00", if_a.rs_data[63:32], if_a.rs_busy);
    end
  endtask

  task automatic test_x_bypass();
    idle_a();
    if_a.wx_v = 1'b1; if_a.wx_addr = 5'd3; if_a.wx_data = 32'h11;
    if_a.rs_addr = {5'd0, 5'd3};
    step();
    checks++;
    if (if_a.rs_data[31:0] !== 32'h11 || if_a.rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL x_byp: data %h busy %b want 11/00", if_a.rs_data[31:0], if_a.rs_busy);
    end
    idle_a();
    if_a.rs_addr = {5'd3, 5'd0};
    step();
    checks++;
    if (if_a.rs_data !== {32'h11, 32'h0}) begin
      errors++; $display("FAIL m_byp: got %h want 00000011_00000000", if_a.rs_data);
    end
    idle_a();
    step();
    if_a.rs_addr = {5'd0, 5'd3};
    step();
    checks++;
    if (if_a.rs_data[31:0] !== 32'h11) begin
      errors++; $display("FAIL arr_r3: got %h want 11", if_a.rs_data[31:0]);
    end
  endtask

  task automatic test_x_beats_m();
    idle_a();
    if_a.wx_v = 1'b1; if_a.wx_addr = 5'd7; if_a.wx_data = 32'hAA;
    step();
    if_a.wx_data = 32'hBB;
    if_a.rs_addr = {5'd7, 5'd7};
    step();
    checks++;
    if (if_a.rs_data !== {32'hBB, 32'hBB}) begin
      errors++; $display("FAIL x_over_m: got %h want both BB", if_a.rs_data);
    end
    idle_a();
    if_a.rs_addr = {5'd7, 5'd0};
    step();
    checks++;
    if (if_a.rs_data[63:32] !== 32'hBB) begin
      errors++; $display("FAIL m_after_x: got %h want BB", if_a.rs_data[63:32]);
    end
  endtask

  task automatic test_load_scoreboard();
    idle_a();
    if_a.ld_issue_v = 1'b1; if_a.ld_issue_addr = 5'd9;
    if_a.rs_addr = {5'd9, 5'd0};
    step();
    checks++;
    if (if_a.rs_busy !== 2'b10 || if_a.pending_any !== 1'b1) begin
      errors++;
      $display("FAIL issue_busy: busy %b pend %b want 10/1", if_a.rs_busy, if_a.pending_any);
    end
    idle_a();
    if_a.rs_addr = {5'd0, 5'd9};
    step();
    checks++;
    if (if_a.rs_busy !== 2'b01) begin
      errors++; $display("FAIL pend_busy: got %b want 01", if_a.rs_busy);
    end
    step();
    if_a.wl_v = 1'b1; if_a.wl_addr = 5'd9; if_a.wl_data = 32'hDEAD;
    if_a.rs_addr = {5'd9, 5'd9};
    step();
    checks++;
    if (if_a.rs_busy !== 2'b00 || if_a.rs_data !== {32'hDEAD, 32'hDEAD}) begin
      errors++;
      $display("FAIL wl_return: busy %b data %h want 00/DEAD", if_a.rs_busy, if_a.rs_data);
    end
    checks++;
    if (if_a.pending_any !== 1'b0) begin
      errors++; $display("FAIL pend_drop: got %b want 0", if_a.pending_any);
    end
    idle_a();
    if_a.rs_addr = {5'd0, 5'd9};
    step();
    checks++;
    if (if_a.rs_data[31:0] !== 32'hDEAD || if_a.rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL arr_r9: data %h busy %b want DEAD/00", if_a.rs_data[31:0], if_a.rs_busy);
    end
  endtask

  task automatic test_set_wins();
    idle_a();
    if_a.ld_issue_v = 1'b1; if_a.ld_issue_addr = 5'd4;
    if_a.wl_v = 1'b1; if_a.wl_addr = 5'd4; if_a.wl_data = 32'h44;
    if_a.rs_addr = {5'd0, 5'd4};
    step();
    checks++;
    if (if_a.rs_busy !== 2'b01 || if_a.rs_data[31:0] !== 32'h44 || if_a.pending_any !== 1'b1) begin
      errors++;
      $display("FAIL set_wins_c1: busy %b data %h pend %b want 01/44/1",
               if_a.rs_busy, if_a.rs_data[31:0], if_a.pending_any);
    end
    idle_a();
    if_a.rs_addr = {5'd0, 5'd4};
    step();
    checks++;
    if (if_a.rs_busy !== 2'b01 || if_a.rs_data[31:0] !== 32'h44) begin
      errors++;
      $display("FAIL set_wins_arr: busy %b data %h want 01/44", if_a.rs_busy, if_a.rs_data[31:0]);
    end
    idle_a();
    if_a.wl_v = 1'b1; if_a.wl_addr = 5'd4; if_a.wl_data = 32'h45;
    step();
    checks++;
    if (if_a.pending_any !== 1'b0) begin
      errors++; $display("FAIL r4_clear: got %b want 0", if_a.pending_any);
    end
  endtask

  task automatic test_reset_mid_load();
    idle_a();
    if_a.ld_issue_v = 1'b1; if_a.ld_issue_addr = 5'd10;
    step();
    checks++;
    if (if_a.pending_any !== 1'b1) begin
      errors++; $display("FAIL mid_pend_set: got %b want 1", if_a.pending_any);
    end
    idle_a();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.pending_any !== 1'b0 || if_a.rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: pend %b busy %b want 0/00", if_a.pending_any, if_a.rs_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    if_a.wl_v = 1'b1; if_a.wl_addr = 5'd10; if_a.wl_data = 32'h1010;
    step();
    idle_a();
    if_a.rs_addr = {5'd0, 5'd10};
    step();
    checks++;
    if (if_a.rs_data[31:0] !== 32'h1010 || if_a.rs_busy !== 2'b00 || if_a.pending_any !== 1'b0) begin
      errors++;
      $display("FAIL late_after_reset: data %h busy %b pend %b want 1010/00/0",
               if_a.rs_data[31:0], if_a.rs_busy, if_a.pending_any);
    end
  endtask

  task automatic test_zero_reg_a();
    idle_a();
    if_a.wx_v = 1'b1; if_a.wx_addr = 5'd0; if_a.wx_data = 32'h55;
    if_a.ld_issue_v = 1'b1; if_a.ld_issue_addr = 5'd0;
    if_a.rs_addr = {5'd0, 5'd0};
    step();
    checks++;
    if (if_a.rs_data !== 64'h0 || if_a.rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL zero_a_c1: data %h busy %b want 0/00", if_a.rs_data, if_a.rs_busy);
    end
    idle_a();
    if_a.wl_v = 1'b1; if_a.wl_addr = 5'd0; if_a.wl_data = 32'h77;
    if_a.rs_addr = {5'd0, 5'd0};
    step();
    checks++;
    if (if_a.rs_data !== 64'h0 || if_a.rs_busy !== 2'b00 || if_a.pending_any !== 1'b0) begin
      errors++;
      $display("FAIL zero_a_c2: data %h busy %b pend %b want 0/00/0",
               if_a.rs_data, if_a.rs_busy, if_a.pending_any);
    end
    idle_a();
    step();
    checks++;
    if (if_a.rs_data !== 64'h0) begin
      errors++; $display("FAIL zero_a_arr: got %h want 0", if_a.rs_data);
    end
  endtask

  task automatic test_multiport_b();
    logic [63:0] v;
    idle_b();
    v = 64'h0123_4567_89AB_CDEF;
    if_b.wx_v = 1'b1; if_b.wx_addr = 4'd5; if_b.wx_data = v;
    if_b.rs_addr = {4'd5, 4'd5, 4'd5};
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (if_b.rs_data[i*64 +: 64] !== v) begin
        errors++; $display("FAIL b_x_port%0d: got %h want %h", i, if_b.rs_data[i*64 +: 64], v);
      end
    end
    idle_b();
    if_b.rs_addr = {4'd5, 4'd5, 4'd5};
    step();
    checks++;
    if (if_b.rs_data !== {v, v, v} || if_b.rs_busy !== 3'b000) begin
      errors++; $display("FAIL b_m_all: data %h busy %b", if_b.rs_data, if_b.rs_busy);
    end
    idle_b();
    if_b.wx_v = 1'b1; if_b.wx_addr = 4'd6; if_b.wx_data = 64'h1111_1111_1111_1111;
    if_b.wl_v = 1'b1; if_b.wl_addr = 4'd6; if_b.wl_data = 64'h2222_2222_2222_2222;
    if_b.rs_addr = {4'd6, 4'd6, 4'd6};
    step();
    checks++;
    if (if_b.rs_data !== {3{64'h1111_1111_1111_1111}}) begin
      errors++; $display("FAIL b_x_over_l: got %h want 1111.. x3", if_b.rs_data);
    end
    idle_b();
    step();
    if_b.rs_addr = {4'd6, 4'd6, 4'd6};
    step();
    checks++;
    if (if_b.rs_data !== {3{64'h1111_1111_1111_1111}}) begin
      errors++; $display("FAIL b_arr_r6: got %h want 1111.. x3", if_b.rs_data);
    end
    idle_b();
    if_b.ld_issue_v = 1'b1; if_b.ld_issue_addr = 4'd3;
    if_b.rs_addr = {4'd3, 4'd3, 4'd3};
    step();
    checks++;
    if (if_b.rs_busy !== 3'b111) begin
      errors++; $display("FAIL b_busy_all: got %b want 111", if_b.rs_busy);
    end
    idle_b();
    if_b.wl_v = 1'b1; if_b.wl_addr = 4'd3; if_b.wl_data = 64'h3;
    step();
    idle_b();
    if_b.wx_v = 1'b1; if_b.wx_addr = 4'd0; if_b.wx_data = '1;
    if_b.ld_issue_v = 1'b1; if_b.ld_issue_addr = 4'd0;
    if_b.rs_addr = {4'd0, 4'd0, 4'd0};
    step();
    checks++;
    if (if_b.rs_data !== 192'h0 || if_b.rs_busy !== 3'b000 || if_b.pending_any !== 1'b0) begin
      errors++;
      $display("FAIL b_zero: data %h busy %b pend %b want 0/000/0",
               if_b.rs_data, if_b.rs_busy, if_b.pending_any);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_x_bypass();
    test_x_beats_m();
    test_load_scoreboard();
    test_set_wins();
    test_reset_mid_load();
    test_zero_reg_a();
    test_multiport_b();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ireg_mp.md
Name: ireg_mp

Overview:
- Parametrised successor to the integer register file for the in-order RISC-V pipeline.
- Provides NRD registered read ports with full X/M/late-write bypass.
- Adds a second, late write port for load/long-latency returns.
- Adds a per-register pending scoreboard so decode can stall on registers not yet written.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers.
- AW, $clog2(NREG), register address width (derived, not overridden).
- NRD, 2, number of read ports.
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never pending.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rs_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW], sampled in decode cycle.
- rs_data  out  NRD*XLEN  read data, valid the cycle after rs_addr.
- rs_busy  out  NRD  read register pending (late write outstanding), aligned with rs_data.
- wx_v  in  1  X-stage result write valid.
- wx_addr  in  AW  X-stage destination.
- wx_data  in  XLEN  X-stage result.
- wl_v  in  1  late write (load return) valid.
- wl_addr  in  AW  late write destination.
- wl_data  in  XLEN  late write data.
- ld_issue_v  in  1  long-latency op issued; marks its destination pending.
- ld_issue_addr  in  AW  destination to mark pending.
- pending_any  out  1  OR of all pending bits.

Behaviour:
- Reset (async, rst_n low):
  - M and W pipeline valids cleared; all pending bits cleared.
  - Bypass selects cleared; rs_data = 0; rs_busy = 0; pending_any = 0.
  - Array contents undefined, except register 0 reads 0 when ZERO_REG = 1.
  - Reset mid-load discards the outstanding pending state; a later wl still writes the array.
- Read timing:
  - Address presented in cycle c, sampled at edge E (end of c); data and busy are observable in cycle c+1.
  - The array is read synchronously with read-before-write at E.
- X write path:
  - wx_v in cycle c latches (addr, data) into stage M at E.
  - M writes the array at the next edge and is copied into stage W at the same edge.
  - W holds its data for one cycle for bypass.
- Late write path: wl_v in cycle c writes the array directly at E.
- Read-data priority for port i reading address a (presented in cycle c), youngest first:
  1. wx_v & wx_addr==a in cycle c -> wx_data.
  2. M valid & M.addr==a in cycle c -> M data.
  3. wl_v & wl_addr==a in cycle c -> wl_data.
  4. Otherwise the array value.
  - Selects are registered at E; the data mux in c+1 is combinational on M/W/late-capture registers.
- ZERO_REG = 1:
  - Address 0 always returns 0 with rs_busy = 0.
  - Writes to register 0 on either port are dropped and never enter M.
  - ld_issue to register 0 is ignored.
- Write collision (M and wl write the same address at the same edge): M wins. This case is illegal by construction (the scoreboard must stall it) and is covered by an assertion.
- Scoreboard:
  - pend[r] is set at E by ld_issue_v and cleared at E by wl_v.
  - If set and clear hit the same address in the same cycle, set wins (a new load follows the old return).
- rs_busy[i] in c+1 = (pend[a] & ~(wl_v & wl_addr==a)) | (ld_issue_v & ld_issue_addr==a), all evaluated in cycle c.
  - A returning load therefore unblocks the reader immediately, with its data bypassed.
- pending_any is registered: the OR of the pend vector after E.
- Multiple read ports may read the same address in the same cycle and must each get identical data and busy.

Decomposition:
- Package ireg_pkg holds:
  - XLEN default;
  - typedef reg_addr_t (logic [AW-1:0] for NREG = 32);
  - enum byp_sel_t {BYP_ARR, BYP_X, BYP_M, BYP_L};
  - localparam ZERO_ADDR = 0.
- One sub-module, ireg_scoreboard, holds the pend vector, the set/clear logic, rs_busy generation and pending_any.
- The read ports are generated with a for-generate loop inside ireg_mp.

Test Plan:
- Reset then read r5, r0 -> rs_data 0,0 and rs_busy 0,0; pending_any 0.
- wx_v r3=0x11 in cycle c while port0 reads r3 in c -> 0x11 in c+1. Port1 reads r3 in c+1 -> 0x11 (M bypass). Read in c+3 -> 0x11 (array).
- wx_v r7=0xAA in c, wx_v r7=0xBB in c+1, port0 reads r7 in c+1 -> 0xBB (X beats M).
- ld_issue r9 in c, read r9 in c+1 -> busy 1. wl_v r9=0xDEAD in c+4 with read r9 in c+4 -> busy 0 and data 0xDEAD in c+5; pending_any drops after c+4.
- ld_issue r4 and wl_v r4 in the same cycle -> r4 remains pending; r4 array value = wl_data.
- ZERO_REG = 1: wx_v r0=0x55 and ld_issue r0, then read r0 -> data 0, busy 0. Repeat with NRD=3, XLEN=64, NREG=16: all three ports read the same bypassed value.
